// File: rtl/b01_pkg.sv
// Shared types for the b01 serial operand driver: FSM state encoding and default width.
// No logic, no latency, no backpressure.
// Imported by b01_shreg and b01_driver.
package b01_pkg;

  localparam int B01_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/b01_shreg.sv
// Parallel-load, right-shifting register whose bit 0 is the registered serial output.
// Load or shift takes effect on the next clock edge; load has priority over shift.
// No backpressure: the owner decides when to load and when to shift.
module b01_shreg
  import b01_pkg::*;
#(
  parameter int WIDTH = B01_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_bit0
);

  logic [WIDTH-1:0] r_q;

  // Zeros shift in from the top, so after WIDTH shifts the serial output is 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_din;
    end else if (i_shift) begin
      r_q <= {1'b0, r_q[WIDTH-1:1]};
    end
  end

  assign o_bit0 = r_q[0];

endmodule

// File: rtl/b01_driver.sv
// Serializes an operand pair LSB-first onto line1/line2 and deserializes the comparator's outp reply.
// Latency: operand accept to res_valid is WIDTH+2 cycles. Optional B01_DRIVER_OVF_EN adds sticky res_ovf.
// Backpressure: op_ready only in IDLE; the result is held in DONE until res_valid & res_ready.
module b01_driver
  import b01_pkg::*;
#(
  parameter int WIDTH = B01_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             line1,
  output logic             line2,
  input  logic             outp,
  input  logic             overflw,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data
`ifdef B01_DRIVER_OVF_EN
  ,
  output logic             res_ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res;
  logic             w_load;
  logic             w_shift;
  logic             w_cap;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_cap       = 1'b0;
    op_ready    = 1'b0;
    res_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        // The reply to bit k arrives one cycle after bit k left, so the first SHIFT cycle captures nothing.
        w_cap   = (r_cnt != '0);
        if (r_cnt == LAST_BIT) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        w_cap       = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_shift) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // r_cnt is one ahead of the bit being answered, including the DRAIN cycle where it equals WIDTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_res <= '0;
    end else if (w_load) begin
      r_res <= '0;
    end else if (w_cap) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_cnt == CW'(i + 1)) begin
          r_res[i] <= outp;
        end
      end
    end
  end

  assign res_data = r_res;

`ifdef B01_DRIVER_OVF_EN
  logic r_ovf;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_load) begin
      r_ovf <= 1'b0;
    end else if (w_cap) begin
      r_ovf <= r_ovf | overflw;
    end
  end

  assign res_ovf = r_ovf;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = overflw;
`endif

  b01_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg_a (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_load),
    .i_shift(w_shift),
    .i_din  (op_a),
    .o_bit0 (line1)
  );

  b01_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg_b (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_load),
    .i_shift(w_shift),
    .i_din  (op_b),
    .o_bit0 (line2)
  );

endmodule

// File: tb/tb_b01_driver.sv
// Bench for b01_driver: an 8-bit instance under full transaction traffic and a 2-bit instance for the narrow case.
module tb_b01_driver;

  logic       clock = 1'b0;
  logic       reset;
  logic       op_valid, op_ready, line1, line2, outp, overflw, res_valid, res_ready;
  logic [7:0] op_a, op_b, res_data;
  logic       op_valid2, op_ready2, line1_2, line2_2, outp2, overflw2, res_valid2, res_ready2;
  logic [1:0] op_a2, op_b2, res_data2;
`ifdef B01_DRIVER_OVF_EN
  logic       res_ovf, res_ovf2;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       ovf;
  } exp_t;

  exp_t       q8[$];
  logic [1:0] q2[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         n_acc = 0;
  int         n_acc_exp = 0;

  always #5 clock = ~clock;

  b01_driver #(.WIDTH(8)) u_dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .line1(line1), .line2(line2), .outp(outp),
    .overflw(overflw), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
`ifdef B01_DRIVER_OVF_EN
    , .res_ovf(res_ovf)
`endif
  );

  b01_driver #(.WIDTH(2)) u_dut2 (
    .clock(clock), .reset(reset), .op_valid(op_valid2), .op_ready(op_ready2),
    .op_a(op_a2), .op_b(op_b2), .line1(line1_2), .line2(line2_2), .outp(outp2),
    .overflw(overflw2), .res_valid(res_valid2), .res_ready(res_ready2), .res_data(res_data2)
`ifdef B01_DRIVER_OVF_EN
    , .res_ovf(res_ovf2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && op_valid && op_ready) n_acc++;
    if (!reset && res_valid && res_ready) begin
      if (q8.size() == 0) begin
        chk("sb8_spurious_result", res_valid, 0);
      end else begin
        e = q8.pop_front();
        chk("sb8_res_data", res_data, e.d);
`ifdef B01_DRIVER_OVF_EN
        chk("sb8_res_ovf", res_ovf, e.ovf);
`endif
      end
    end
  end

  always @(negedge clock) begin
    logic [1:0] e2;
    if (!reset && res_valid2 && res_ready2) begin
      if (q2.size() == 0) begin
        chk("sb2_spurious_result", res_valid2, 0);
      end else begin
        e2 = q2.pop_front();
        chk("sb2_res_data", res_data2, e2);
`ifdef B01_DRIVER_OVF_EN
        chk("sb2_res_ovf", res_ovf2, 0);
`endif
      end
    end
  end

  // Entered just after a rising edge; returns just after the edge that completes the result handshake.
  task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] resp,
                     input bit ovf_on, input bit hold_vld, input bit early_rdy, input int hold);
    int w;
    op_a     = a;
    op_b     = b;
    op_valid = 1'b1;
    w        = 0;
    @(negedge clock);
    while (!op_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    chk("op_ready_idle", op_ready, 1);
    chk("res_valid_idle", res_valid, 0);
    q8.push_back('{d: resp, ovf: ovf_on});
    n_acc_exp++;
    @(posedge clock); #1;
    if (!hold_vld) op_valid = 1'b0;
    res_ready = early_rdy;
    for (int c = 1; c <= 8; c++) begin
      outp    = (c >= 2) ? resp[c-2] : 1'b0;
      overflw = ovf_on && (c == 4);
      @(negedge clock);
      chk("line1", line1, a[c-1]);
      chk("line2", line2, b[c-1]);
      chk("op_ready_busy", op_ready, 0);
      chk("res_valid_early", res_valid, 0);
      @(posedge clock); #1;
    end
    outp    = resp[7];
    overflw = 1'b0;
    @(negedge clock);
    chk("lines_drain", {line1, line2}, 0);
    chk("op_ready_drain", op_ready, 0);
    chk("res_valid_drain", res_valid, 0);
    @(posedge clock); #1;
    outp = 1'b0;
    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0;
      @(negedge clock);
      chk("res_valid_hold", res_valid, 1);
      chk("res_data_hold", res_data, resp);
      chk("op_ready_done", op_ready, 0);
      @(posedge clock); #1;
    end
    res_ready = 1'b1;
    @(negedge clock);
    chk("res_valid_done", res_valid, 1);
    @(posedge clock); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    op_valid = 0; op_a = 0; op_b = 0; outp = 0; overflw = 0; res_ready = 0;
    op_valid2 = 0; op_a2 = 0; op_b2 = 0; outp2 = 0; overflw2 = 0; res_ready2 = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_lines", {line1, line2}, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst2_op_ready", op_ready2, 1);
    chk("rst2_res_data", res_data2, 0);
    @(posedge clock); #1;

    txn(8'hA5, 8'h0F, 8'h53, 1'b1, 1'b0, 1'b0, 5);
    txn(8'h3C, 8'hC3, 8'hAA, 1'b0, 1'b0, 1'b1, 0);
    txn(8'hFF, 8'h00, 8'h81, 1'b0, 1'b1, 1'b0, 1);
    txn(8'h01, 8'h80, 8'h7E, 1'b0, 1'b0, 1'b0, 2);

    // Abandon a transaction with reset in its 4th shift cycle while op_valid is also high.
    op_a = 8'h96; op_b = 8'h69; op_valid = 1'b1;
    @(negedge clock);
    chk("abort_op_ready", op_ready, 1);
    n_acc_exp++;
    @(posedge clock); #1;
    op_valid  = 1'b0;
    res_ready = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
    end
    reset = 1'b1; op_valid = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; op_valid = 1'b0;
    @(negedge clock);
    chk("abort_op_ready_after", op_ready, 1);
    chk("abort_lines", {line1, line2}, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_res_data", res_data, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk("abort_no_result", res_valid, 0);
    end
    res_ready = 1'b0;
    @(posedge clock); #1;

    txn(8'h5A, 8'hA5, 8'h0F, 1'b0, 1'b0, 1'b0, 1);

    op_a2 = 2'b10; op_b2 = 2'b01; op_valid2 = 1'b1;
    @(negedge clock);
    chk("w2_op_ready", op_ready2, 1);
    q2.push_back(2'b01);
    @(posedge clock); #1;
    op_valid2 = 1'b0; outp2 = 1'b0;
    @(negedge clock);
    chk("w2_c1_line1", line1_2, 0);
    chk("w2_c1_line2", line2_2, 1);
    @(posedge clock); #1;
    outp2 = 1'b1;
    @(negedge clock);
    chk("w2_c2_line1", line1_2, 1);
    chk("w2_c2_line2", line2_2, 0);
    @(posedge clock); #1;
    outp2 = 1'b0;
    @(negedge clock);
    chk("w2_drain_valid", res_valid2, 0);
    chk("w2_drain_lines", {line1_2, line2_2}, 0);
    @(posedge clock); #1;
    res_ready2 = 1'b1;
    @(negedge clock);
    chk("w2_done_valid", res_valid2, 1);
    @(posedge clock); #1;
    res_ready2 = 1'b0;
    @(negedge clock);
    chk("w2_valid_drop", res_valid2, 0);
    chk("w2_op_ready_back", op_ready2, 1);

    chk("final_res_valid", res_valid, 0);
    chk("final_op_ready", op_ready, 1);
    chk("sb8_leftover", q8.size(), 0);
    chk("sb2_leftover", q2.size(), 0);
    chk("accept_count", n_acc, n_acc_exp);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "simulation time limit reached");
  end

endmodule
